// File: rtl/spi2apb_bridge_if.sv
// APB bus between the SPI bridge (requester) and the APB completer.
interface spi2apb_bridge_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/spi2apb_bridge.sv
// SPI mode-0 slave that turns 8-bit command frames into single APB reads/writes.
// SPI pins are oversampled in the pclk domain; sclk must be at most pclk/8.
module spi2apb_bridge #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    spi2apb_bridge_if.master apb,
    output logic             apb_err,
    output logic             frame_abort
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 7;
    localparam int unsigned CNT_W  = 6;

    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] DUMMY_BITS = CNT_W'(8);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDUMMY,
        S_RDATA,
        S_DONE
    } frame_state_e;

    typedef enum logic [1:0] {
        A_IDLE,
        A_SETUP,
        A_ACCESS
    } apb_state_e;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q,   cs_sync_q,   cs_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    always_ff @(posedge pclk) begin
        if (preset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= spi_sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= spi_cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    logic sclk_rise_c, sclk_fall_c, cs_fall_c;

    assign sclk_rise_c = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall_c = ~sclk_sync_q & sclk_prev_q;
    assign cs_fall_c   = cs_prev_q & ~cs_sync_q;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    frame_state_e       fstate_q, fstate_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               miso_q, miso_d;
    logic               abort_q, abort_d;

    logic               launch_c;
    logic               launch_wr_c;
    logic [IDX_W-1:0]   launch_idx_c;

    apb_state_e         astate_q, astate_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    always_ff @(posedge pclk) begin
        if (preset) begin
            fstate_q  <= S_IDLE;
            bit_cnt_q <= '0;
            cmd_q     <= '0;
            shift_q   <= '0;
            miso_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            fstate_q  <= fstate_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_q     <= cmd_d;
            shift_q   <= shift_d;
            miso_q    <= miso_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        fstate_d     = fstate_q;
        bit_cnt_d    = bit_cnt_q;
        cmd_d        = cmd_q;
        shift_d      = shift_q;
        miso_d       = miso_q;
        abort_d      = 1'b0;
        launch_c     = 1'b0;
        launch_wr_c  = 1'b0;
        launch_idx_c = cmd_q[IDX_W-1:0];

        if (cs_sync_q) begin
            // CS released: any frame still collecting or returning bits is cut short
            fstate_d  = S_IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            if (fstate_q inside {S_CMD, S_WDATA, S_RDUMMY, S_RDATA}) begin
                abort_d = 1'b1;
            end
        end else begin
            unique case (fstate_q)
                S_IDLE: begin
                    miso_d = 1'b0;
                    if (cs_fall_c) begin
                        fstate_d  = S_CMD;
                        bit_cnt_d = '0;
                        cmd_d     = '0;
                        shift_d   = '0;
                    end
                end

                S_CMD: begin
                    miso_d = 1'b0;
                    if (sclk_rise_c) begin
                        cmd_d     = {cmd_q[6:0], mosi_sync_q};
                        bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                        if (bit_cnt_q == CMD_LAST) begin
                            bit_cnt_d = '0;
                            if (astate_q != A_IDLE) begin
                                fstate_d = S_DONE;
                                abort_d  = 1'b1;
                            end else if (cmd_d[7]) begin
                                fstate_d = S_WDATA;
                            end else begin
                                fstate_d     = S_RDUMMY;
                                launch_c     = 1'b1;
                                launch_idx_c = cmd_d[IDX_W-1:0];
                            end
                        end
                    end
                end

                S_WDATA: begin
                    miso_d = 1'b0;
                    if (sclk_rise_c) begin
                        shift_d   = {shift_q[DATA_W-2:0], mosi_sync_q};
                        bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            fstate_d  = S_DONE;
                            if (astate_q != A_IDLE) begin
                                abort_d = 1'b1;
                            end else begin
                                launch_c    = 1'b1;
                                launch_wr_c = 1'b1;
                            end
                        end
                    end
                end

                S_RDUMMY: begin
                    miso_d = 1'b0;
                    if (sclk_rise_c && (bit_cnt_q != DUMMY_BITS)) begin
                        bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                    end
                    // Read word is committed on the falling edge after the dummy byte
                    if (sclk_fall_c && (bit_cnt_q == DUMMY_BITS)) begin
                        fstate_d  = S_RDATA;
                        bit_cnt_d = '0;
                        if (rvalid_q) begin
                            shift_d = rdata_q;
                        end else begin
                            shift_d = '0;
                            abort_d = 1'b1;
                        end
                        miso_d = shift_d[DATA_W-1];
                    end
                end

                S_RDATA: begin
                    if (sclk_fall_c) begin
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        miso_d  = shift_q[DATA_W-2];
                    end
                    if (sclk_rise_c) begin
                        if (bit_cnt_q == DATA_LAST) begin
                            fstate_d  = S_DONE;
                            bit_cnt_d = '0;
                            miso_d    = 1'b0;
                        end else begin
                            bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
                        end
                    end
                end

                S_DONE: begin
                    miso_d = 1'b0;
                end

                default: begin
                    fstate_d = S_IDLE;
                    miso_d   = 1'b0;
                end
            endcase
        end

        // Look one synchronizer stage ahead so miso is low in the same cycle CS reads high
        if (cs_meta_q) begin
            miso_d = 1'b0;
        end
    end

    assign spi_miso    = miso_q;
    assign frame_abort = abort_q;

    // ------------------------------------------------------------------
    // APB requester FSM
    // ------------------------------------------------------------------
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              apb_err_q, apb_err_d;

    always_ff @(posedge pclk) begin
        if (preset) begin
            astate_q  <= A_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            apb_err_q <= 1'b0;
        end else begin
            astate_q  <= astate_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            apb_err_q <= apb_err_d;
        end
    end

    always_comb begin
        astate_d  = astate_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        apb_err_d = 1'b0;

        unique case (astate_q)
            A_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (launch_c) begin
                    astate_d = A_SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = launch_wr_c;
                    paddr_d  = ADDR_BASE + {23'h0, launch_idx_c, 2'b00};
                    rvalid_d = 1'b0;
                    if (launch_wr_c) begin
                        pwdata_d = shift_d;
                    end
                end
            end

            A_SETUP: begin
                astate_d  = A_ACCESS;
                penable_d = 1'b1;
            end

            A_ACCESS: begin
                if (apb.pready) begin
                    astate_d  = A_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    apb_err_d = apb.pslverr;
                    if (!pwrite_q) begin
                        rdata_d  = apb.prdata;
                        rvalid_d = 1'b1;
                    end
                end
            end

            default: begin
                astate_d  = A_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    assign apb.paddr   = paddr_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
    assign apb_err     = apb_err_q;

endmodule

// File: tb/tb_spi2apb_bridge.sv
// Bench for spi2apb_bridge: SPI master driver, APB completer with memory, and a word-level reference model.
`timescale 1ns/1ps
module tb_spi2apb_bridge;

    localparam logic [31:0] ADDR_BASE = 32'h4000_0000;
    localparam int          HALF      = 50;

    logic pclk = 1'b0;
    logic preset;
    logic spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic apb_err, frame_abort;

    spi2apb_bridge_if bus ();

    spi2apb_bridge #(.ADDR_BASE(ADDR_BASE)) dut (
        .pclk       (pclk),
        .preset     (preset),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .apb        (bus),
        .apb_err    (apb_err),
        .frame_abort(frame_abort)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Completer configuration (written by the stimulus only)
    int   wait_n = 0;
    logic err_en = 1'b0;

    // Completer / monitor state (written by the negedge process only)
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic        q_wr[$];
    int          q_pen[$];
    int          q_setup[$];
    int          wcnt = 0, cyc = 0, pen_run = 0, setup_run = 0;
    int          stab_bad = 0, n_abort = 0, n_err = 0;
    int          last_done_cyc = 0, err_gap = 0;
    logic [31:0] stab_addr, stab_data;
    logic        stab_wr;

    // Reference model: word memory indexed by the 7-bit command index
    logic [31:0] ref_mem [int];

    // APB completer with wait states plus a bus monitor, all on the falling edge
    always @(negedge pclk) begin
        cyc = cyc + 1;
        if (preset || !bus.psel) begin
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            wcnt        = 0;
            pen_run     = 0;
            if (preset) setup_run = 0;
        end else if (bus.penable) begin
            if (wcnt >= wait_n) begin
                bus.pready  = 1'b1;
                bus.pslverr = err_en;
            end else begin
                bus.pready  = 1'b0;
                bus.pslverr = 1'b0;
                wcnt        = wcnt + 1;
            end
        end
        bus.prdata = (bus.psel && slv_mem.exists(bus.paddr)) ? slv_mem[bus.paddr] : 32'h0;

        if (!preset && bus.psel) begin
            if (!bus.penable) begin
                setup_run = setup_run + 1;
                stab_addr = bus.paddr;
                stab_wr   = bus.pwrite;
                stab_data = bus.pwdata;
            end else begin
                pen_run = pen_run + 1;
                if (bus.paddr !== stab_addr || bus.pwrite !== stab_wr || bus.pwdata !== stab_data)
                    stab_bad = stab_bad + 1;
                if (bus.pready) begin
                    q_addr.push_back(bus.paddr);
                    q_data.push_back(bus.pwdata);
                    q_wr.push_back(bus.pwrite);
                    q_pen.push_back(pen_run);
                    q_setup.push_back(setup_run);
                    if (bus.pwrite) slv_mem[bus.paddr] = bus.pwdata;
                    last_done_cyc = cyc;
                    pen_run       = 0;
                    setup_run     = 0;
                end
            end
        end
        if (frame_abort === 1'b1) n_abort = n_abort + 1;
        if (apb_err === 1'b1) begin
            n_err   = n_err + 1;
            err_gap = cyc - last_done_cyc;
        end
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [6:0] idx);
        return ADDR_BASE + 32'(idx) * 32'd4;
    endfunction

    function automatic logic [31:0] ref_val(input logic [6:0] idx);
        return ref_mem.exists(int'(idx)) ? ref_mem[int'(idx)] : 32'h0;
    endfunction

    // Mode-0 SPI master: drive MOSI while SCLK is low, sample MISO on the rising edge
    task automatic spi_frame(input logic [79:0] tx, input int nbits, output logic [31:0] rx);
        logic [79:0] r;
        r = '0;
        spi_cs_n = 1'b0;
        #(2*HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[79-i];
            #(HALF);
            spi_sclk = 1'b1;
            r = {r[78:0], spi_miso};
            #(HALF);
            spi_sclk = 1'b0;
        end
        #(HALF);
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        #(2*HALF);
        rx = r[31:0];
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        @(negedge pclk);
        while (bus.psel && t < 3000) begin
            @(negedge pclk);
            t = t + 1;
        end
        chk({tag, "_idle_timeout"}, 32'(bus.psel), 32'd0);
    endtask

    task automatic do_write(input logic [6:0] idx, input logic [31:0] data, input logic exp_err);
        int q0, a0, e0;
        logic [31:0] rx;
        q0 = q_addr.size(); a0 = n_abort; e0 = n_err;
        spi_frame({1'b1, idx, data, 40'h0}, 40, rx);
        wait_idle("wr");
        repeat (3) @(negedge pclk);
        chk("wr_count", 32'(q_addr.size() - q0), 32'd1);
        if (q_addr.size() > q0) begin
            chk("wr_paddr",   q_addr[q0], exp_addr(idx));
            chk("wr_pwrite",  32'(q_wr[q0]), 32'd1);
            chk("wr_pwdata",  q_data[q0], data);
            chk("wr_setup",   32'(q_setup[q0]), 32'd1);
            chk("wr_penable", 32'(q_pen[q0]), 32'(wait_n + 1));
        end
        chk("wr_miso_quiet", rx, 32'h0);
        chk("wr_abort", 32'(n_abort - a0), 32'd0);
        chk("wr_err",   32'(n_err - e0), 32'(exp_err));
        ref_mem[int'(idx)] = data;
    endtask

    task automatic do_read(input logic [6:0] idx, input logic late);
        int q0, a0, e0;
        logic [31:0] rx, exp;
        exp = late ? 32'h0 : ref_val(idx);
        q0 = q_addr.size(); a0 = n_abort; e0 = n_err;
        spi_frame({1'b0, idx, 72'h0}, 48, rx);
        wait_idle("rd");
        repeat (3) @(negedge pclk);
        chk("rd_data",  rx, exp);
        chk("rd_count", 32'(q_addr.size() - q0), 32'd1);
        if (q_addr.size() > q0) begin
            chk("rd_paddr",   q_addr[q0], exp_addr(idx));
            chk("rd_pwrite",  32'(q_wr[q0]), 32'd0);
            chk("rd_setup",   32'(q_setup[q0]), 32'd1);
            chk("rd_penable", 32'(q_pen[q0]), 32'(wait_n + 1));
        end
        chk("rd_abort", 32'(n_abort - a0), 32'(late));
        chk("rd_err",   32'(n_err - e0), 32'd0);
    endtask

    initial begin
        int q0, a0, e0, t;
        logic [31:0] rx, d;
        logic [6:0]  idx;

        // Reset values
        preset = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        repeat (4) @(posedge pclk);
        #1;
        chk("rst_psel",    32'(bus.psel), 32'd0);
        chk("rst_penable", 32'(bus.penable), 32'd0);
        chk("rst_pwrite",  32'(bus.pwrite), 32'd0);
        chk("rst_paddr",   bus.paddr, 32'd0);
        chk("rst_pwdata",  bus.pwdata, 32'd0);
        chk("rst_miso",    32'(spi_miso), 32'd0);
        chk("rst_pulses",  32'({apb_err, frame_abort}), 32'd0);
        @(negedge pclk);
        preset = 1'b0;
        repeat (5) @(negedge pclk);

        // Basic write (cmd 8'h83) and read-back of a known word at index 5
        do_write(7'd3, 32'hA5A5_1234, 1'b0);
        do_write(7'd5, 32'hDEAD_BEEF, 1'b0);
        do_read(7'd5, 1'b0);
        do_read(7'd3, 1'b0);

        // Randomized traffic with short wait states
        for (int k = 0; k < 8; k++) begin
            idx    = 7'($urandom_range(0, 7));
            wait_n = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) do_write(idx, $urandom, 1'b0);
            else                           do_read(idx, 1'b0);
        end

        // Three wait states: penable held four cycles, data intact
        wait_n = 3;
        do_read(7'd5, 1'b0);

        // Read still pending when the word must be shifted out
        wait_n = 150;
        do_read(7'd3, 1'b1);
        wait_n = 0;

        // CS released after 20 write data bits
        q0 = q_addr.size(); a0 = n_abort;
        spi_frame({1'b1, 7'd12, 32'h1357_9BDF, 40'h0}, 28, rx);
        repeat (20) @(negedge pclk);
        chk("abort_no_access", 32'(q_addr.size() - q0), 32'd0);
        chk("abort_pulse",     32'(n_abort - a0), 32'd1);
        do_write(7'd12, 32'h2468_ACE0, 1'b0);
        do_read(7'd12, 1'b0);

        // Slave error on write completion
        err_en = 1'b1;
        do_write(7'd6, 32'h0BAD_F00D, 1'b1);
        chk("err_gap", 32'(err_gap), 32'd1);
        err_en = 1'b0;

        // Command arriving while the previous access is still stalled is dropped
        wait_n = 400;
        q0 = q_addr.size(); a0 = n_abort; e0 = n_err;
        d = $urandom;
        spi_frame({1'b1, 7'd9, d, 40'h0}, 40, rx);
        spi_frame({1'b0, 7'd9, 72'h0}, 48, rx);
        wait_idle("drop");
        repeat (3) @(negedge pclk);
        chk("drop_count", 32'(q_addr.size() - q0), 32'd1);
        chk("drop_miso",  rx, 32'h0);
        chk("drop_abort", 32'(n_abort - a0), 32'd1);
        chk("drop_err",   32'(n_err - e0), 32'd0);
        ref_mem[9] = d;
        wait_n = 0;
        do_read(7'd9, 1'b0);

        // Reset while the access is stretched in ACCESS
        wait_n = 1000;
        q0 = q_addr.size(); a0 = n_abort; e0 = n_err;
        spi_frame({1'b1, 7'd20, 32'hFACE_CAFE, 40'h0}, 40, rx);
        t = 0;
        while (!bus.penable && t < 200) begin
            @(negedge pclk);
            t = t + 1;
        end
        chk("rst_in_access", 32'(bus.penable), 32'd1);
        preset = 1'b1;
        @(posedge pclk);
        #1;
        chk("rst_mid_psel",    32'(bus.psel), 32'd0);
        chk("rst_mid_penable", 32'(bus.penable), 32'd0);
        chk("rst_mid_miso",    32'(spi_miso), 32'd0);
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        wait_n = 0;
        repeat (20) @(negedge pclk);
        chk("rst_mid_access", 32'(q_addr.size() - q0), 32'd0);
        chk("rst_mid_abort",  32'(n_abort - a0), 32'd0);
        chk("rst_mid_err",    32'(n_err - e0), 32'd0);
        do_write(7'd20, 32'h0F0F_5A5A, 1'b0);
        do_read(7'd20, 1'b0);

        chk("apb_stable", 32'(stab_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi2apb_bridge.md
SPI2APB_BRIDGE -- requirements
Module: spi2apb_bridge

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000, APB base address added to every decoded word offset.
REQ-002 SHALL have ports, clock and reset first:
  pclk        in   1   system/APB clock; all logic on rising edge
  preset      in   1   synchronous, active-high reset
  spi_sclk    in   1   SPI clock from external master, asynchronous to pclk
  spi_cs_n    in   1   SPI chip select, active low, asynchronous
  spi_mosi    in   1   SPI data from master, asynchronous
  spi_miso    out  1   SPI data to master
  paddr       out  32  APB address
  psel        out  1   APB select
  penable     out  1   APB enable
  pwrite      out  1   APB direction, 1 = write
  pwdata      out  32  APB write data
  prdata      in   32  APB read data
  pready      in   1   APB ready
  pslverr     in   1   APB slave error
  apb_err     out  1   one-cycle pulse: completed APB access had pslverr=1
  frame_abort out  1   one-cycle pulse: CS deasserted mid-frame or frame dropped
REQ-003 SHALL use a single clock, pclk, and a synchronous active-high reset, preset.

Function
REQ-004 SHALL pass spi_sclk, spi_cs_n and spi_mosi through 2-flop synchronizers; edges are detected on synchronized sclk; spi_sclk SHALL be at most pclk/8.
REQ-005 SHALL implement SPI mode 0 only, MSB first: mosi sampled on sclk rising edge, miso updated on sclk falling edge.
REQ-006 Frame FSM states SHALL be S_IDLE, S_CMD, S_WDATA, S_RDUMMY, S_RDATA, S_DONE.
REQ-007 Synchronized CS falling edge in S_IDLE -> S_CMD with bit counter cleared; synchronized CS high in any state -> S_IDLE on the next cycle.
REQ-008 Command byte: bit7 = write (1) / read (0), bits[6:0] = word index; paddr SHALL be ADDR_BASE + {23'h0, index, 2'b00}, modulo 2^32.
REQ-009 After the 8th command bit: write -> S_WDATA; read -> S_RDUMMY and the APB read SHALL launch on the next pclk.
REQ-010 S_WDATA SHALL shift in 32 bits MSB first; after the 32nd bit the word SHALL be latched into pwdata, an APB write SHALL launch, and the FSM SHALL move to S_DONE.
REQ-011 S_RDUMMY SHALL last 8 bits, with miso = 0; on the falling edge following its 8th rising edge, miso SHALL present bit31 of the read word and the FSM SHALL move to S_RDATA.
REQ-012 If the APB read has not completed when the read word is loaded, the word SHALL be 32'h0000_0000 and frame_abort SHALL pulse.
REQ-013 S_RDATA SHALL shift out 32 bits, then move to S_DONE.
REQ-014 S_DONE SHALL ignore further sclk edges; miso = 0.
REQ-015 spi_miso SHALL be 0 whenever synchronized CS is high; the output is never tristated.
REQ-016 APB FSM states SHALL be A_IDLE, A_SETUP, A_ACCESS.
REQ-017 Launch -> A_SETUP with psel=1, penable=0 for exactly one cycle; then A_ACCESS with psel=1, penable=1, held until pready=1; then A_IDLE with psel=0, penable=0.
REQ-018 paddr, pwrite and pwdata SHALL be stable from A_SETUP until the end of A_ACCESS.
REQ-019 The read word SHALL be captured from prdata in the A_ACCESS cycle where pready=1.
REQ-020 If pslverr=1 in the completing cycle, apb_err SHALL pulse on the following cycle; read data is still returned.
REQ-021 CS deassertion during S_CMD, S_WDATA, S_RDUMMY or S_RDATA SHALL pulse frame_abort; a write with fewer than 32 data bits SHALL never launch.
REQ-022 An APB access already in A_SETUP or A_ACCESS SHALL complete regardless of CS.
REQ-023 If a command completes while the APB FSM is not in A_IDLE, the frame SHALL be dropped (-> S_DONE), frame_abort SHALL pulse, and no new access SHALL launch.

Reset
REQ-024 While preset=1 at a pclk edge: both FSMs idle; psel, penable, pwrite, apb_err, frame_abort and spi_miso = 0; paddr, pwdata, shift registers and counters = 0; synchronizers loaded with cs_n=1, sclk=0, mosi=0.
REQ-025 Reset mid-frame or mid-APB access SHALL abort immediately with no frame_abort pulse; the next frame SHALL need a fresh CS falling edge.

Verification
REQ-026 Write: cmd 8'h83, data 32'hA5A5_1234, pready=1 -> one write, paddr=32'h0C, pwdata=32'hA5A5_1234, SETUP then ACCESS, apb_err=0.
REQ-027 Read: ADDR_BASE=32'h4000_0000, cmd 8'h05, prdata=32'hDEAD_BEEF, pready=1 -> paddr=32'h4000_0014, pwrite=0, MISO bytes DE AD BE EF after the dummy byte.
REQ-028 Wait states: read with pready low 3 cycles -> penable held 4 cycles, data correct; pready low past the dummy byte -> MISO 32'h0 and one frame_abort pulse.
REQ-029 Abort: CS high after 20 write data bits -> no psel, one frame_abort pulse; the next full write completes normally.
REQ-030 Error: write with pslverr=1 at completion -> exactly one apb_err pulse one cycle after the access ends.
REQ-031 Reset: preset asserted during A_ACCESS -> psel=0 and penable=0 after the next pclk edge, miso=0, no pulses.
